// File: rtl/riscv_perf_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_perf_counter_unit
// Purpose  : Configurable event counters with overflow/IRQ, preload,
//            atomic snapshot and registered readback.
// Revision : 1.0
// ============================================================================
module riscv_perf_counter_unit #(
    parameter  int NUM_COUNTERS = 8,
    parameter  int CNT_WIDTH    = 64,
    parameter  int NUM_EVENTS   = 16,
    localparam int EVSEL_W      = (NUM_EVENTS   > 1) ? $clog2(NUM_EVENTS)   : 1,
    localparam int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_EVENTS-1:0]   event_i,
    input  logic                    freeze_i,
    input  logic                    cfg_we_i,
    input  logic [IDX_W-1:0]        cfg_idx_i,
    input  logic [EVSEL_W-1:0]      cfg_evsel_i,
    input  logic                    cfg_en_i,
    input  logic                    cfg_irq_en_i,
    input  logic                    cnt_we_i,
    input  logic [IDX_W-1:0]        cnt_idx_i,
    input  logic [CNT_WIDTH-1:0]    cnt_wdata_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    input  logic                    rd_snap_i,
    output logic [CNT_WIDTH-1:0]    rd_data_o,
    input  logic                    snap_req_i,
    output logic                    snap_done_o,
    output logic [NUM_COUNTERS-1:0] ovf_o,
    input  logic [NUM_COUNTERS-1:0] ovf_clr_i,
    output logic                    irq_o
);

    logic [CNT_WIDTH-1:0]    r_cnt   [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    r_snap  [NUM_COUNTERS];
    logic [EVSEL_W-1:0]      r_evsel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] r_en;
    logic [NUM_COUNTERS-1:0] r_irq_en;
    logic [NUM_COUNTERS-1:0] r_ovf;
    logic [CNT_WIDTH-1:0]    r_rd_data;
    logic                    r_snap_done;
    logic                    r_irq;

    logic [NUM_COUNTERS-1:0] w_inc;
    logic [NUM_COUNTERS-1:0] w_ld;
    logic [NUM_COUNTERS-1:0] w_cfg;
    logic [NUM_COUNTERS-1:0] w_wrap;
    logic [CNT_WIDTH-1:0]    w_rd_data;

    // Out-of-range indices match no counter, so such writes fall away naturally.
    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        logic w_sel;

        always_comb begin
            w_sel = 1'b0;
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (r_evsel[i] == EVSEL_W'(e)) begin
                    w_sel = event_i[e];
                end
            end
        end

        assign w_inc[i]  = r_en[i] & ~freeze_i & w_sel;
        assign w_ld[i]   = cnt_we_i & (cnt_idx_i == IDX_W'(i));
        assign w_cfg[i]  = cfg_we_i & (cfg_idx_i == IDX_W'(i));
        assign w_wrap[i] = w_inc[i] & ~w_ld[i] & (&r_cnt[i]);
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                w_rd_data = rd_snap_i ? r_snap[i] : r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt[i]   <= '0;
                r_snap[i]  <= '0;
                r_evsel[i] <= '0;
            end
            r_en        <= '0;
            r_irq_en    <= '0;
            r_ovf       <= '0;
            r_rd_data   <= '0;
            r_snap_done <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (w_ld[i]) begin
                    r_cnt[i] <= cnt_wdata_i;
                end else if (w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
                if (snap_req_i) begin
                    r_snap[i] <= r_cnt[i];
                end
                if (w_cfg[i]) begin
                    r_evsel[i]  <= cfg_evsel_i;
                    r_en[i]     <= cfg_en_i;
                    r_irq_en[i] <= cfg_irq_en_i;
                end
                // A new wrap outranks a same-cycle clear.
                r_ovf[i] <= w_wrap[i] | (r_ovf[i] & ~ovf_clr_i[i]);
            end
            r_rd_data   <= w_rd_data;
            r_snap_done <= snap_req_i;
            r_irq       <= |(r_ovf & r_irq_en);
        end
    end

    assign rd_data_o   = r_rd_data;
    assign snap_done_o = r_snap_done;
    assign ovf_o       = r_ovf;
    assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_riscv_perf_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_perf_counter_unit
// Purpose  : Directed self-checking bench for riscv_perf_counter_unit.
// Revision : 1.0
// ============================================================================
module tb_riscv_perf_counter_unit;

    localparam int NUM_COUNTERS = 6;
    localparam int CNT_WIDTH    = 32;
    localparam int NUM_EVENTS   = 12;
    localparam int EVSEL_W      = 4;
    localparam int IDX_W        = 3;

    logic                    clk_i;
    logic                    rst_ni;
    logic [NUM_EVENTS-1:0]   event_i;
    logic                    freeze_i;
    logic                    cfg_we_i;
    logic [IDX_W-1:0]        cfg_idx_i;
    logic [EVSEL_W-1:0]      cfg_evsel_i;
    logic                    cfg_en_i;
    logic                    cfg_irq_en_i;
    logic                    cnt_we_i;
    logic [IDX_W-1:0]        cnt_idx_i;
    logic [CNT_WIDTH-1:0]    cnt_wdata_i;
    logic [IDX_W-1:0]        rd_idx_i;
    logic                    rd_snap_i;
    logic [CNT_WIDTH-1:0]    rd_data_o;
    logic                    snap_req_i;
    logic                    snap_done_o;
    logic [NUM_COUNTERS-1:0] ovf_o;
    logic [NUM_COUNTERS-1:0] ovf_clr_i;
    logic                    irq_o;

    int checks = 0;
    int errors = 0;

    riscv_perf_counter_unit #(
        .NUM_COUNTERS (NUM_COUNTERS),
        .CNT_WIDTH    (CNT_WIDTH),
        .NUM_EVENTS   (NUM_EVENTS)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .event_i      (event_i),
        .freeze_i     (freeze_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_evsel_i  (cfg_evsel_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_irq_en_i (cfg_irq_en_i),
        .cnt_we_i     (cnt_we_i),
        .cnt_idx_i    (cnt_idx_i),
        .cnt_wdata_i  (cnt_wdata_i),
        .rd_idx_i     (rd_idx_i),
        .rd_snap_i    (rd_snap_i),
        .rd_data_o    (rd_data_o),
        .snap_req_i   (snap_req_i),
        .snap_done_o  (snap_done_o),
        .ovf_o        (ovf_o),
        .ovf_clr_i    (ovf_clr_i),
        .irq_o        (irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input int idx, input int evsel, input logic en, input logic irq_en);
        cfg_we_i     = 1'b1;
        cfg_idx_i    = IDX_W'(idx);
        cfg_evsel_i  = EVSEL_W'(evsel);
        cfg_en_i     = en;
        cfg_irq_en_i = irq_en;
    endtask

    task automatic load(input int idx, input logic [CNT_WIDTH-1:0] val);
        cnt_we_i    = 1'b1;
        cnt_idx_i   = IDX_W'(idx);
        cnt_wdata_i = val;
    endtask

    task automatic read_chk(input string tag, input int idx, input logic snap, input logic [63:0] exp);
        rd_idx_i  = IDX_W'(idx);
        rd_snap_i = snap;
        tick();
        check(tag, 64'(rd_data_o), exp);
    endtask

    initial begin
        rst_ni = 1'b1;
        event_i = '0; freeze_i = 1'b0;
        cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_evsel_i = '0; cfg_en_i = 1'b0; cfg_irq_en_i = 1'b0;
        cnt_we_i = 1'b0; cnt_idx_i = '0; cnt_wdata_i = '0;
        rd_idx_i = '0; rd_snap_i = 1'b0; snap_req_i = 1'b0; ovf_clr_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_rd_data", 64'(rd_data_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_snap_done", 64'(snap_done_o), 64'd0);
        tick(); tick();
        rst_ni = 1'b1;

        // Basic counting: counter 0 on event 0 for ten cycles
        cfg(0, 0, 1'b1, 1'b0);
        tick();
        cfg_we_i = 1'b0;
        event_i  = 12'h001;
        repeat (10) tick();
        event_i = '0;
        read_chk("cnt0_ten", 0, 1'b0, 64'd10);
        read_chk("cnt1_disabled", 1, 1'b0, 64'd0);

        // evsel beyond NUM_EVENTS selects nothing
        cfg(3, 12, 1'b1, 1'b0);
        tick();
        cfg_we_i = 1'b0;
        event_i  = '1;
        repeat (3) tick();
        event_i = '0;
        read_chk("cnt3_evsel_oor", 3, 1'b0, 64'd0);
        read_chk("cnt0_all_events", 0, 1'b0, 64'd13);

        // Wrap, overflow, irq and clear on counter 2
        load(2, '1);
        cfg(2, 5, 1'b1, 1'b1);
        tick();
        cnt_we_i = 1'b0; cfg_we_i = 1'b0;
        check("load_no_ovf", 64'(ovf_o), 64'd0);
        event_i = 12'h020;
        tick();
        event_i = '0;
        check("wrap_ovf", 64'(ovf_o), 64'h04);
        check("irq_lag", 64'(irq_o), 64'd0);
        tick();
        check("irq_set", 64'(irq_o), 64'd1);
        read_chk("cnt2_wrapped", 2, 1'b0, 64'd0);
        ovf_clr_i = 6'b000100;
        tick();
        ovf_clr_i = '0;
        check("ovf_cleared", 64'(ovf_o), 64'd0);
        check("irq_hold", 64'(irq_o), 64'd1);
        tick();
        check("irq_cleared", 64'(irq_o), 64'd0);

        // Set beats clear; dropping irq_en releases irq
        load(2, '1);
        tick();
        cnt_we_i  = 1'b0;
        event_i   = 12'h020;
        ovf_clr_i = 6'b000100;
        tick();
        event_i = '0; ovf_clr_i = '0;
        check("set_wins", 64'(ovf_o), 64'h04);
        tick();
        check("irq_set2", 64'(irq_o), 64'd1);
        cfg(2, 5, 1'b0, 1'b0);
        tick();
        cfg_we_i = 1'b0;
        tick();
        check("irq_en_drop", 64'(irq_o), 64'd0);
        check("ovf_sticky", 64'(ovf_o), 64'h04);
        ovf_clr_i = 6'b000100;
        tick();
        ovf_clr_i = '0;

        // Load overrides increment; freeze holds
        load(4, 32'd5);
        cfg(4, 7, 1'b1, 1'b0);
        tick();
        cfg_we_i = 1'b0;
        event_i  = 12'h080;
        load(4, 32'd100);
        tick();
        cnt_we_i = 1'b0;
        freeze_i = 1'b1;
        repeat (4) tick();
        read_chk("load_wins_freeze", 4, 1'b0, 64'd100);
        freeze_i = 1'b0;
        event_i  = '0;

        // Same-cycle write is not visible in the read
        rd_idx_i = 3'd4; rd_snap_i = 1'b0;
        load(4, 32'd55);
        tick();
        cnt_we_i = 1'b0;
        check("read_pre_write", 64'(rd_data_o), 64'd100);
        tick();
        check("read_post_write", 64'(rd_data_o), 64'd55);

        // Snapshot of counters at 7 and 9 while counting
        load(0, 32'd7);
        cfg(1, 0, 1'b1, 1'b0);
        tick();
        cfg_we_i = 1'b0;
        load(1, 32'd9);
        tick();
        cnt_we_i   = 1'b0;
        event_i    = 12'h001;
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        check("snap_done_pulse", 64'(snap_done_o), 64'd1);
        tick();
        event_i = '0;
        check("snap_done_low", 64'(snap_done_o), 64'd0);
        read_chk("snap0", 0, 1'b1, 64'd7);
        read_chk("snap1", 1, 1'b1, 64'd9);
        read_chk("live0", 0, 1'b0, 64'd9);
        read_chk("live1", 1, 1'b0, 64'd11);

        // Back-to-back snapshots, taken while frozen
        freeze_i   = 1'b1;
        snap_req_i = 1'b1;
        tick();
        check("b2b_done1", 64'(snap_done_o), 64'd1);
        tick();
        snap_req_i = 1'b0;
        check("b2b_done2", 64'(snap_done_o), 64'd1);
        tick();
        check("b2b_done_low", 64'(snap_done_o), 64'd0);
        freeze_i = 1'b0;
        read_chk("snap1_frozen", 1, 1'b1, 64'd11);

        // Out-of-range indices
        cfg(6, 0, 1'b1, 1'b1);
        load(6, 32'hAA);
        tick();
        cfg(7, 0, 1'b1, 1'b1);
        load(7, 32'hBB);
        tick();
        cfg_we_i = 1'b0; cnt_we_i = 1'b0;
        read_chk("oor_read6", 6, 1'b0, 64'd0);
        read_chk("oor_read7_snap", 7, 1'b1, 64'd0);
        read_chk("cnt5_untouched", 5, 1'b0, 64'd0);

        // Asynchronous reset mid-operation
        load(2, '1);
        cfg(2, 5, 1'b1, 1'b1);
        tick();
        cnt_we_i = 1'b0; cfg_we_i = 1'b0;
        event_i = 12'h020;
        tick();
        event_i    = '0;
        rd_idx_i   = 3'd0; rd_snap_i = 1'b0;
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        check("pre_rst_irq", 64'(irq_o), 64'd1);
        check("pre_rst_rd", 64'(rd_data_o), 64'd9);
        check("pre_rst_ovf", 64'(ovf_o), 64'h04);
        check("pre_rst_done", 64'(snap_done_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_ovf", 64'(ovf_o), 64'd0);
        check("arst_irq", 64'(irq_o), 64'd0);
        check("arst_rd", 64'(rd_data_o), 64'd0);
        check("arst_done", 64'(snap_done_o), 64'd0);
        tick(); tick();
        rst_ni = 1'b1;
        read_chk("post_rst_cnt0", 0, 1'b0, 64'd0);
        read_chk("post_rst_snap1", 1, 1'b1, 64'd0);
        event_i = 12'h020;
        repeat (2) tick();
        event_i = '0;
        read_chk("post_rst_cfg_cleared", 2, 1'b0, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
